// File: rtl/dct32_odd_ctrl.sv
// Purpose : sequencing for the odd half of a 32-point DCT. Buffers 32 samples,
//           drives the 16 butterfly differences to an external shift-add datapath,
//           then captures the 16 odd coefficients and streams them out.
// Latency : first coefficient is valid 3 cycles after the 32nd sample is accepted
//           (CALC, CAPT, DRAIN). If the previous block is still draining, it is
//           valid 3 cycles after that block's y31 handshake.
// Backpressure: valid/ready on both sides. The next block's samples load while
//           draining. in_ready drops once 32 samples are held and comes back after CALC.
// Ports   : clk, rst_b (async active-low); in_valid/in_ready/in_data sample stream;
//           dp_rst/dp_b/dp_y external datapath; out_valid/out_ready/out_data/
//           out_idx/out_last coefficient stream; busy status.
module dct32_odd_ctrl #(
    parameter int IN_WIDTH = 16,
    parameter int WIDTH    = 20
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  dp_rst,
    output logic [16*WIDTH-1:0]   dp_b,
    input  logic [16*WIDTH-1:0]   dp_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [4:0]            out_idx,
    output logic                  out_last,
    output logic                  busy
);

    typedef enum logic [1:0] {LOAD, CALC, CAPT, DRAIN} state_t;

    state_t state, state_nxt;

    logic [5:0]                 ld_cnt;
    logic [3:0]                 rd_cnt;
    logic signed [IN_WIDTH-1:0] xbuf   [32];
    logic [WIDTH-1:0]           obuf   [16];
    logic [WIDTH-1:0]           b_now  [16];
    logic [WIDTH-1:0]           b_hold [16];
    logic                       in_hs;
    logic                       out_hs;
    logic                       ld_full_nxt;

    // ld_cnt only reaches 32 once a whole block is held, which also covers CALC.
    // Gating with rst_b keeps in_ready low for the whole reset.
    assign in_ready  = rst_b & ~ld_cnt[5];
    assign in_hs     = in_valid & in_ready;
    assign out_valid = (state == DRAIN);
    assign out_hs    = out_valid & out_ready;
    assign dp_rst    = ~rst_b;
    assign busy      = !((state == LOAD) && (ld_cnt == 6'd0));

    // A full block is available after this edge. The 32nd sample may land
    // on the same edge as the y31 handshake.
    assign ld_full_nxt = ld_cnt[5] | (in_hs && (ld_cnt == 6'd31));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:  if (in_hs && (ld_cnt == 6'd31)) state_nxt = CALC;
            CALC:  state_nxt = CAPT;
            CAPT:  state_nxt = DRAIN;
            DRAIN: if (out_hs && (rd_cnt == 4'hF)) state_nxt = ld_full_nxt ? CALC : LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ld_cnt <= 6'd0;
            rd_cnt <= 4'd0;
        end else begin
            if (state == CALC) begin
                ld_cnt <= 6'd0;
            end else if (in_hs) begin
                ld_cnt <= ld_cnt + 6'd1;
            end
            // rd_cnt wraps to 0 after y31, ready for the next block.
            if (out_hs) begin
                rd_cnt <= rd_cnt + 4'd1;
            end
        end
    end

    // Sample storage. Stale contents are harmless because ld_cnt decides what is valid.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            xbuf[ld_cnt[4:0]] <= in_data;
        end
    end

    // Butterfly differences at IN_WIDTH+1 bits. The differences are exact
    // at that width, then sign-extended to WIDTH.
    always_comb begin
        logic signed [IN_WIDTH:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) begin
            d        = (IN_WIDTH+1)'(xbuf[k]) - (IN_WIDTH+1)'(xbuf[31-k]);
            b_now[k] = WIDTH'(d);
        end
    end

    // The datapath needs b during CALC itself, so CALC drives the live
    // differences and the register holds them afterwards.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < 16; k++) begin
                b_hold[k] <= '0;
                obuf[k]   <= '0;
            end
        end else begin
            if (state == CALC) begin
                for (int k = 0; k < 16; k++) begin
                    b_hold[k] <= b_now[k];
                end
            end
            if (state == CAPT) begin
                for (int k = 0; k < 16; k++) begin
                    obuf[k] <= dp_y[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        dp_b = '0;
        for (int k = 0; k < 16; k++) begin
            dp_b[k*WIDTH +: WIDTH] = (state == CALC) ? b_now[k] : b_hold[k];
        end
    end

    // Outputs are zero outside DRAIN. Inside DRAIN they are a function
    // of rd_cnt alone, so they stay stable while stalled.
    always_comb begin
        out_data = '0;
        out_idx  = 5'd0;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = obuf[rd_cnt];
            out_idx  = {rd_cnt, 1'b1};
            out_last = (rd_cnt == 4'hF);
        end
    end

endmodule

// File: tb/tb_dct32_odd_ctrl.sv
module tb_dct32_odd_ctrl;

    localparam int IN_W = 16;
    localparam int W    = 20;

    logic                clk = 1'b0;
    logic                rst_b;
    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic                dp_rst;
    logic [16*W-1:0]     dp_b;
    logic [16*W-1:0]     dp_y;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [4:0]          out_idx;
    logic                out_last;
    logic                busy;

    always #5 clk = ~clk;

    dct32_odd_ctrl #(.IN_WIDTH(IN_W), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .dp_rst    (dp_rst),
        .dp_b      (dp_b),
        .dp_y      (dp_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    int nchecks = 0;
    int nerr    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Odd DCT-32 coefficient magnitudes (HEVC integer basis).
    int ctab [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};

    // Matrix entry for row y(2m+1) and column b(k), from cos(pi*(2m+1)(2k+1)/64).
    function automatic int coef(input int m, input int k);
        int a;
        a = ((2*m+1) * (2*k+1)) % 128;
        if (a < 32)      return  ctab[(a-1)/2];
        else if (a < 64) return -ctab[(63-a)/2];
        else if (a < 96) return -ctab[(a-65)/2];
        else             return  ctab[(127-a)/2];
    endfunction

    // External shift-add datapath model. It registers y = M*b every cycle.
    function automatic logic [16*W-1:0] dp_model(input logic [16*W-1:0] b);
        logic [16*W-1:0]     r;
        logic signed [W-1:0] t;
        longint              s;
        r = '0;
        for (int m = 0; m < 16; m++) begin
            s = 0;
            for (int k = 0; k < 16; k++) begin
                t = b[k*W +: W];
                s += longint'(t) * longint'(coef(m, k));
            end
            r[m*W +: W] = s[W-1:0];
        end
        return r;
    endfunction

    always @(posedge clk or posedge dp_rst) begin
        if (dp_rst) dp_y <= '0;
        else        dp_y <= dp_model(dp_b);
    end

    // Reference: y(2m+1) = sum_k M[m][k]*(x[k]-x[31-k]), wrapped to W bits.
    function automatic logic signed [W-1:0] model_y(input logic [IN_W-1:0] xs [32], input int m);
        longint s;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            s += longint'(coef(m, k)) *
                 (longint'($signed(xs[k])) - longint'($signed(xs[31-k])));
        end
        return s[W-1:0];
    endfunction

    typedef struct {
        logic signed [W-1:0] data;
        logic [4:0]          idx;
        logic                last;
    } beat_t;

    beat_t           exp_q [$];
    int              blk_q [$];
    logic [IN_W-1:0] cur [32];
    int              nin      = 0;
    int              cyc      = 0;
    int              last_y31 = -1000;
    bit              started  = 0;
    beat_t           e;

    // Compare process. Inputs and outputs are stable at the negedge for the following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_b) begin
            nin      = 0;
            exp_q.delete();
            blk_q.delete();
            started  = 0;
            last_y31 = -1000;
            chk("rst_out_valid", out_valid, 0);
        end else begin
            if (in_valid && in_ready) begin
                cur[nin] = in_data;
                nin++;
                if (nin == 32) begin
                    for (int m = 0; m < 16; m++) begin
                        e.data = model_y(cur, m);
                        e.idx  = 5'(2*m+1);
                        e.last = (m == 15);
                        exp_q.push_back(e);
                    end
                    blk_q.push_back(cyc);
                    nin = 0;
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_valid, 0);
                end else begin
                    if (!started) begin
                        started = 1;
                        // A block can start only after its last sample is in and the previous block has drained.
                        chk("first_beat_latency", cyc,
                            ((blk_q[0] > last_y31) ? blk_q[0] : last_y31) + 3);
                    end
                    chk("out_data", $signed(out_data), exp_q[0].data);
                    chk("out_idx",  out_idx,  exp_q[0].idx);
                    chk("out_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        if (exp_q[0].last) begin
                            last_y31 = cyc;
                            started  = 0;
                            void'(blk_q.pop_front());
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 3 = manual.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic feed(input logic [IN_W-1:0] xs [32], input int vprob);
        int   i;
        int   budget;
        logic hs;
        i = 0;
        budget = 0;
        while (i < 32 && budget < 4000) begin
            in_valid = (int'($urandom_range(0, 99)) < vprob);
            in_data  = xs[i];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            budget++;
        end
        in_valid = 1'b0;
        if (i != 32) chk("feed_timeout", i, 32);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain_complete", exp_q.size(), 0);
        chk("busy_idle", busy, (nin == 0) ? 0 : 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [4:0] idx);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (out_valid && out_idx == idx) break;
        end
        chk("wait_idx_seen", out_idx, idx);
    endtask

    logic [IN_W-1:0] imp [32];
    logic [IN_W-1:0] mir [32];
    logic [IN_W-1:0] cst [32];
    logic [IN_W-1:0] rnd [32];

    initial begin
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 32; n++) begin
            imp[n] = (n == 0)  ? 16'd1 : 16'd0;
            mir[n] = (n == 31) ? 16'd1 : 16'd0;
            cst[n] = 16'd1000;
        end

        // Pin the reference model against hand-derived values.
        for (int m = 0; m < 16; m++) begin
            chk("pin_impulse", model_y(imp, m), ctab[m]);
            chk("pin_mirror",  model_y(mir, m), -ctab[m]);
            chk("pin_const",   model_y(cst, m), 0);
        end

        // Reset state, then the first cycle after release.
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx",  out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_dp_rst",   dp_rst, 1);
        chk("rst_dp_b_zero", (dp_b == '0), 1);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("idle_in_ready",  in_ready, 1);
        chk("idle_busy",      busy, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_dp_rst",    dp_rst, 0);
        @(posedge clk);
        #1;

        // Impulse, mirror impulse and constant input.
        feed(imp, 100);
        wait_idle();
        feed(mir, 70);
        wait_idle();
        feed(cst, 100);
        wait_idle();

        // Back-pressure on the third beat.
        feed(imp, 100);
        wait_idx(5'd3);
        @(posedge clk);
        #1;
        rdy_mode  = 3;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", $signed(out_data), 88);
            chk("bp_hold_idx",  out_idx, 5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rdy_mode  = 0;
        wait_idle();

        // Overlap: a full next block arrives while the current one is stalled.
        feed(imp, 100);
        wait_idx(5'd1);
        @(posedge clk);
        #1;
        rdy_mode  = 3;
        out_ready = 1'b0;
        for (int n = 0; n < 32; n++) rnd[n] = 16'($urandom);
        feed(rnd, 100);
        repeat (4) begin
            @(negedge clk);
            chk("ovl_in_ready_low", in_ready, 0);
            chk("ovl_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rdy_mode  = 0;
        wait_idle();

        // Reset pulsed during the eighth beat, then a fresh impulse.
        feed(imp, 100);
        wait_idx(5'd15);
        #2;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy",      busy, 0);
        chk("mid_rst_in_ready",  in_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        feed(imp, 100);
        wait_idle();

        // Random traffic with random throttling on both sides.
        rdy_mode = 1;
        for (int b = 0; b < 6; b++) begin
            for (int n = 0; n < 32; n++) begin
                case ($urandom_range(0, 3))
                    0:       rnd[n] = 16'h7FFF;
                    1:       rnd[n] = 16'h8000;
                    default: rnd[n] = 16'($urandom);
                endcase
            end
            feed(rnd, int'($urandom_range(40, 100)));
        end
        wait_idle();
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #5000000;
        nerr++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dct32_odd_ctrl.md
DCT32_ODD_CTRL -- requirements
Module: dct32_odd_ctrl

Interface
REQ-001 Parameter IN_WIDTH, default 16, signed input sample width.
REQ-002 Parameter WIDTH, default 20, datapath and output width; WIDTH SHALL be >= IN_WIDTH+1.
REQ-003 clk  in  1  single rising-edge clock.
REQ-004 rst_b  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  input sample valid.
REQ-006 in_ready  out  1  block accepts a sample this cycle.
REQ-007 in_data  in  IN_WIDTH  signed sample x[n], n = 0..31 in arrival order.
REQ-008 dp_rst  out  1  active-high reset to the odd-part shift-add datapath; equals ~rst_b.
REQ-009 dp_b  out  16*WIDTH  packed butterfly terms b0..b15 to the datapath; b0 in bits [WIDTH-1:0].
REQ-010 dp_y  in  16*WIDTH  packed registered datapath results y1,y3,..,y31; y1 in the LSB slice.
REQ-011 out_valid  out  1  odd coefficient valid.
REQ-012 out_ready  in  1  downstream accepts the coefficient.
REQ-013 out_data  out  WIDTH  signed odd coefficient.
REQ-014 out_idx  out  5  coefficient index, 1..31 odd.
REQ-015 out_last  out  1  high with the y31 beat.
REQ-016 busy  out  1  high in any state other than LOAD with zero samples held.

Function
REQ-017 An input handshake occurs when in_valid & in_ready at a rising edge; an output handshake occurs when out_valid & out_ready.
REQ-018 Input samples SHALL be written to a 32-entry buffer at position ld_cnt; ld_cnt (0..32) increments per input handshake.
REQ-019 FSM states: LOAD, CALC, CAPT, DRAIN.
REQ-020 LOAD: in_ready = (ld_cnt < 32); transition to CALC on the edge of the 32nd input handshake.
REQ-021 CALC (one cycle): dp_b[k] = x[k] - x[31-k], computed at IN_WIDTH+1 bits and sign-extended to WIDTH; the datapath registers dp_y at the end of CALC; ld_cnt is cleared; next state CAPT.
REQ-022 dp_b SHALL hold its CALC value until the next CALC.
REQ-023 CAPT (one cycle): all 16 dp_y slices are latched into a 16-entry output buffer; next state DRAIN; in_ready = 1.
REQ-024 Latency: the first out_valid is high in the third cycle after the edge of the 32nd input handshake, i.e. CALC, CAPT, then DRAIN.
REQ-025 DRAIN: out_valid = 1; entries are emitted in order y1, y3, .., y31 using rd_cnt 0..15; out_idx = 2*rd_cnt+1; out_last = (rd_cnt == 15).
REQ-026 out_data, out_idx and out_last SHALL be stable while out_valid & !out_ready.
REQ-027 DRAIN SHALL accept the next block's samples with in_ready = (ld_cnt < 32).
REQ-028 On the y31 output handshake: go to CALC if ld_cnt == 32, including when the 32nd sample is accepted on that same edge; otherwise go to LOAD, retaining ld_cnt.
REQ-029 If ld_cnt reaches 32 during DRAIN, in_ready SHALL drop to 0 until CALC clears ld_cnt.
REQ-030 Arithmetic wraps modulo 2^WIDTH; the controller adds no saturation or rounding.

Reset
REQ-031 While rst_b = 0: state LOAD, ld_cnt = 0, rd_cnt = 0, dp_b = 0, output buffer = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0.
REQ-032 in_ready SHALL be 0 while rst_b = 0 and 1 in the first cycle after release.
REQ-033 Reset asserted mid-block SHALL discard all buffered samples and pending outputs immediately; out_valid falls asynchronously.

Verification
REQ-034 Reset then idle: out_valid = 0, busy = 0, in_ready = 1 in the cycle after rst_b rises.
REQ-035 Impulse: x0 = 1, x1..x31 = 0, out_ready = 1 -> 16 beats 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4 with out_idx 1,3,..,31; out_last only on idx 31; first beat 3 cycles after the 32nd accept.
REQ-036 Mirror impulse: x31 = 1, others 0 -> the same 16 magnitudes negated (-90..-4); constant input x[n] = 1000 -> all 16 outputs 0.
REQ-037 Back-pressure: out_ready low for 5 cycles at the third beat -> out_data = 88 and out_idx = 5 held throughout; no beat lost or duplicated.
REQ-038 Overlap: the next block is streamed during DRAIN with its 32nd sample accepted before y31 -> in_ready = 0 until CALC, CALC follows the y31 handshake directly, and the second block's results are correct.
REQ-039 rst_b pulsed low at the eighth DRAIN beat -> out_valid = 0 immediately, and a fresh block afterwards yields the correct impulse response.
